// File: rtl/tcp_pkg.sv
// Shared definitions for the TCP segment transmitter: flag bit positions,
// header geometry and the serializer state encoding.
package tcp_pkg;

  localparam int unsigned TCP_FLAG_FIN = 0;
  localparam int unsigned TCP_FLAG_SYN = 1;
  localparam int unsigned TCP_FLAG_RST = 2;
  localparam int unsigned TCP_FLAG_PSH = 3;
  localparam int unsigned TCP_FLAG_ACK = 4;

  localparam int unsigned TCP_HDR_BYTES   = 20;
  localparam int unsigned TCP_HDR_WORDS   = TCP_HDR_BYTES / 2;
  localparam logic [3:0]  TCP_DATA_OFFSET = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR,
    ST_FETCH,
    ST_PAY,
    ST_DONE
  } tcp_tx_state_e;

endpackage

// File: rtl/tcp_csum16.sv
// 16-bit one's-complement accumulator with end-around carry; the output is
// the inverted running sum, i.e. the value placed in the checksum field.
module tcp_csum16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic [15:0] i_word,
  output logic [15:0] o_csum_c
);

  logic [15:0] r_acc;
  logic [16:0] w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_word};

  // Fold the carry back in; acc + word <= 0x1FFFE so one fold is enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= 16'h0000;
    end else if (i_clear) begin
      r_acc <= 16'h0000;
    end else if (i_add) begin
      r_acc <= w_sum[15:0] + 16'(w_sum[16]);
    end
  end

  assign o_csum_c = ~r_acc;

endmodule

// File: rtl/tcp_segment_tx.sv
// Serializes one TCP segment per mainfsm request: 20-byte big-endian header,
// followed by PAYLOAD_LEN bytes from a synchronous-read memory for data
// segments. Define TCP_TX_CHECKSUM_EN to compute the header checksum
// (extra CSUM pass of 10 cycles); otherwise the checksum field is zero.
module tcp_segment_tx
  import tcp_pkg::*;
#(
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd80,
  parameter logic [15:0] WINDOW      = 16'd3,
  parameter int unsigned PAYLOAD_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readyout,
  input  logic [31:0] seq_in,
  input  logic [31:0] ack_in,
  input  logic [8:0]  flags_in,
  input  logic        control,
  output logic        busy,
  output logic        packetsent,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data
);

  localparam logic [4:0] LAST_HDR_BYTE = 5'(TCP_HDR_BYTES - 1);
  localparam logic [4:0] LAST_HDR_WORD = 5'(TCP_HDR_WORDS - 1);
  localparam logic [7:0] LAST_PAY_BYTE = 8'(PAYLOAD_LEN - 1);

  tcp_tx_state_e r_state;
  logic [4:0]    r_idx;
  logic [7:0]    r_k;
  logic [31:0]   r_seq;
  logic [31:0]   r_ack;
  logic [8:0]    r_flags;
  logic          r_control;
  logic          r_busy;
  logic          r_packetsent;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_tx_last;
  logic [15:0]   r_mem_addr;

  logic          w_hs;
  logic          w_accept;
  logic [4:0]    w_idx_nxt;
  logic [15:0]   w_csum;
  logic [15:0]   w_hdr_csum;
  logic [15:0]   w_csum_word;
  logic [15:0]   w_hdr_word_nxt;
  logic [7:0]    w_hdr_byte_nxt;

  // Header word w (0..9), big-endian, from the latched segment fields.
  function automatic logic [15:0] hdr_word(input logic [3:0]  w,
                                           input logic [31:0] seq,
                                           input logic [31:0] ack,
                                           input logic [8:0]  flags,
                                           input logic [15:0] csum);
    logic [15:0] v;
    case (w)
      4'd0:    v = SRC_PORT;
      4'd1:    v = DST_PORT;
      4'd2:    v = seq[31:16];
      4'd3:    v = seq[15:0];
      4'd4:    v = ack[31:16];
      4'd5:    v = ack[15:0];
      4'd6:    v = {TCP_DATA_OFFSET, 3'b000, flags};
      4'd7:    v = WINDOW;
      4'd8:    v = csum;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  assign w_hs      = r_tx_valid & tx_ready;
  assign w_accept  = (r_state == ST_IDLE) & readyout;
  assign w_idx_nxt = r_idx + 5'd1;

`ifdef TCP_TX_CHECKSUM_EN
  assign w_hdr_csum = w_csum;
`else
  logic w_unused_csum;
  assign w_unused_csum = ^w_csum;
  assign w_hdr_csum    = 16'h0000;
`endif

  // The checksum pass sums header words with the checksum field as zero.
  assign w_csum_word    = hdr_word(r_idx[3:0], r_seq, r_ack, r_flags, 16'h0000);
  assign w_hdr_word_nxt = hdr_word(w_idx_nxt[4:1], r_seq, r_ack, r_flags, w_hdr_csum);
  assign w_hdr_byte_nxt = w_idx_nxt[0] ? w_hdr_word_nxt[7:0] : w_hdr_word_nxt[15:8];

  tcp_csum16 u_csum (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_add    (r_state == ST_CSUM),
    .i_word   (w_csum_word),
    .o_csum_c (w_csum)
  );

  // Segment sequencer. mem_addr is prefetched one byte ahead so the byte for
  // payload index k is already on mem_data during its FETCH cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= 5'd0;
      r_k          <= 8'd0;
      r_seq        <= 32'h0;
      r_ack        <= 32'h0;
      r_flags      <= 9'h0;
      r_control    <= 1'b0;
      r_busy       <= 1'b0;
      r_packetsent <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_last    <= 1'b0;
      r_mem_addr   <= 16'h0000;
    end else begin
      r_packetsent <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (readyout) begin
            r_seq      <= seq_in;
            r_ack      <= ack_in;
            r_flags    <= flags_in;
            r_control  <= control;
            r_busy     <= 1'b1;
            r_idx      <= 5'd0;
            r_k        <= 8'd0;
            r_mem_addr <= seq_in[15:0] * 16'(PAYLOAD_LEN);
`ifdef TCP_TX_CHECKSUM_EN
            r_state    <= ST_CSUM;
`else
            r_state    <= ST_HDR;
            r_tx_valid <= 1'b1;
            r_tx_data  <= SRC_PORT[15:8];
            r_tx_last  <= 1'b0;
`endif
          end
        end
        ST_CSUM: begin
          if (r_idx == LAST_HDR_WORD) begin
            r_state    <= ST_HDR;
            r_idx      <= 5'd0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= SRC_PORT[15:8];
            r_tx_last  <= 1'b0;
          end else begin
            r_idx <= w_idx_nxt;
          end
        end
        ST_HDR: begin
          if (w_hs) begin
            if (r_idx == LAST_HDR_BYTE) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              if (r_control) begin
                r_state      <= ST_DONE;
                r_packetsent <= 1'b1;
              end else begin
                r_state <= ST_FETCH;
              end
            end else begin
              r_idx     <= w_idx_nxt;
              r_tx_data <= w_hdr_byte_nxt;
              r_tx_last <= r_control & (w_idx_nxt == LAST_HDR_BYTE);
            end
          end
        end
        ST_FETCH: begin
          r_state    <= ST_PAY;
          r_tx_valid <= 1'b1;
          r_tx_data  <= mem_data;
          r_tx_last  <= (r_k == LAST_PAY_BYTE);
          r_mem_addr <= r_mem_addr + 16'd1;
        end
        ST_PAY: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            if (r_k == LAST_PAY_BYTE) begin
              r_state      <= ST_DONE;
              r_packetsent <= 1'b1;
            end else begin
              r_k     <= r_k + 8'd1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign packetsent = r_packetsent;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign tx_last    = r_tx_last;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_tcp_segment_tx.sv
// Directed bench for tcp_segment_tx: control/data segments, back-pressure,
// ignored requests and mid-segment reset, with hand-computed header bytes.
module tb_tcp_segment_tx;
  import tcp_pkg::*;

`ifdef TCP_TX_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  localparam int FV = CS_EN ? 11 : 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        readyout = 1'b0;
  logic [31:0] seq_in = 32'h0;
  logic [31:0] ack_in = 32'h0;
  logic [8:0]  flags_in = 9'h0;
  logic        control = 1'b0;
  logic        busy, packetsent, tx_valid, tx_last;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] cap_data [0:63];
  logic       cap_last [0:63];
  int cap_n, first_valid, busy_c1, last_hs, ps_cycle, ps_count, busy_after, valid_after;
  logic [7:0] stall_data [0:15];
  logic       stall_valid [0:15];
  int stall_n;

  tcp_segment_tx dut (
    .clk        (clk),
    .reset      (reset),
    .readyout   (readyout),
    .seq_in     (seq_in),
    .ack_in     (ack_in),
    .flags_in   (flags_in),
    .control    (control),
    .busy       (busy),
    .packetsent (packetsent),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read payload memory whose content is the address low byte.
  always @(posedge clk) mem_data <= mem_addr[7:0];

  task automatic issue(input logic [31:0] s, input logic [31:0] a,
                       input logic [8:0] f, input logic c);
    @(posedge clk); #1;
    seq_in = s; ack_in = a; flags_in = f; control = c; readyout = 1'b1;
  endtask

  // Records one segment starting the cycle after issue(); optional stall,
  // extra readyout while busy and extra readyout in the packetsent cycle.
  task automatic capture(input int stall_byte, input int stall_len,
                         input int ro_busy_cyc, input bit ro_done);
    int cyc;
    int remaining;
    bit fin;
    cap_n = 0; first_valid = -1; busy_c1 = -1; last_hs = -1;
    ps_cycle = -1; ps_count = 0; busy_after = -1; valid_after = 0; stall_n = 0;
    remaining = stall_len;
    @(posedge clk); #1;
    readyout = 1'b0;
    seq_in = 32'hA5A5_A5A5; ack_in = 32'h5A5A_5A5A; flags_in = 9'h1FF; control = ~control;
    cyc = 1;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (cyc == 1) busy_c1 = int'(busy);
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (!tx_ready && stall_n < 16) begin
        stall_data[stall_n] = tx_data;
        stall_valid[stall_n] = tx_valid;
        stall_n++;
      end
      if (tx_valid && tx_ready) begin
        if (cap_n < 64) begin
          cap_data[cap_n] = tx_data;
          cap_last[cap_n] = tx_last;
        end
        cap_n++;
        last_hs = cyc;
      end
      if (packetsent) begin
        ps_count++;
        if (ps_cycle < 0) ps_cycle = cyc;
      end
      if (ps_cycle >= 0 && cyc == ps_cycle + 1) busy_after = int'(busy);
      if (ps_cycle >= 0 && cyc > ps_cycle && tx_valid) valid_after++;
      if ((ps_cycle >= 0 && cyc >= ps_cycle + 4) || cyc >= 300) begin
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        readyout = 1'b0;
        if (cyc == ro_busy_cyc) begin
          readyout = 1'b1; seq_in = 32'hDEAD_BEEF; control = 1'b0;
        end
        if (ro_done && packetsent) begin
          readyout = 1'b1; seq_in = 32'hCAFE_F00D; control = 1'b1;
        end
        tx_ready = 1'b1;
        if (remaining > 0 && tx_valid && cap_n == stall_byte) begin
          tx_ready = 1'b0;
          remaining--;
        end
      end
    end
    readyout = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (packetsent !== 1'b0) $display("FAIL reset_packetsent got %b want 0", packetsent); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else n_pass++;
    n_total++; if (tx_last !== 1'b0) $display("FAIL reset_tx_last got %b want 0", tx_last); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else n_pass++;
    n_total++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h want 0000", mem_addr); else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_syn_control();
    logic [7:0] e [0:19];
    int nlast;
    e = '{8'h13, 8'h88, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h50, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    e[16] = CS_EN ? 8'h9C : 8'h00;
    e[17] = CS_EN ? 8'h22 : 8'h00;
    issue(32'h0, 32'h0, 9'(1 << TCP_FLAG_SYN), 1'b1);
    capture(-1, 0, -1, 1'b0);
    n_total++; if (cap_n !== 20) $display("FAIL syn_len got %0d want 20", cap_n); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_total++;
      if (cap_data[i] !== e[i]) $display("FAIL syn_byte%0d got %h want %h", i, cap_data[i], e[i]);
      else n_pass++;
    end
    nlast = 0;
    for (int i = 0; i < 20; i++) if (cap_last[i] === 1'b1) nlast++;
    n_total++; if (nlast !== 1 || cap_last[19] !== 1'b1) $display("FAIL syn_last count %0d last19 %b want 1/1", nlast, cap_last[19]); else n_pass++;
    n_total++; if (busy_c1 !== 1) $display("FAIL syn_busy_c1 got %0d want 1", busy_c1); else n_pass++;
    n_total++; if (first_valid !== FV) $display("FAIL syn_first_valid got %0d want %0d", first_valid, FV); else n_pass++;
    n_total++; if (last_hs !== FV + 19) $display("FAIL syn_last_hs got %0d want %0d", last_hs, FV + 19); else n_pass++;
    n_total++; if (ps_cycle !== FV + 20) $display("FAIL syn_ps_cycle got %0d want %0d", ps_cycle, FV + 20); else n_pass++;
    n_total++; if (ps_count !== 1) $display("FAIL syn_ps_count got %0d want 1", ps_count); else n_pass++;
    n_total++; if (busy_after !== 0) $display("FAIL syn_busy_after got %0d want 0", busy_after); else n_pass++;
  endtask

  task automatic test_data_segment();
    logic [7:0] e [0:27];
    int nlast;
    e = '{8'h13, 8'h88, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01,
          8'h00, 8'h02, 8'h50, 8'h18, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    e[16] = CS_EN ? 8'h9C : 8'h00;
    e[17] = CS_EN ? 8'h07 : 8'h00;
    issue(32'h0000_0002, 32'h0001_0002, 9'h018, 1'b0);
    capture(-1, 0, -1, 1'b0);
    n_total++; if (cap_n !== 28) $display("FAIL data_len got %0d want 28", cap_n); else n_pass++;
    for (int i = 0; i < 28; i++) begin
      n_total++;
      if (cap_data[i] !== e[i]) $display("FAIL data_byte%0d got %h want %h", i, cap_data[i], e[i]);
      else n_pass++;
    end
    nlast = 0;
    for (int i = 0; i < 28; i++) if (cap_last[i] === 1'b1) nlast++;
    n_total++; if (nlast !== 1 || cap_last[27] !== 1'b1) $display("FAIL data_last count %0d last27 %b want 1/1", nlast, cap_last[27]); else n_pass++;
    n_total++; if (last_hs !== FV + 35) $display("FAIL data_last_hs got %0d want %0d", last_hs, FV + 35); else n_pass++;
    n_total++; if (ps_cycle !== FV + 36) $display("FAIL data_ps_cycle got %0d want %0d", ps_cycle, FV + 36); else n_pass++;
    n_total++; if (ps_count !== 1) $display("FAIL data_ps_count got %0d want 1", ps_count); else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] e [0:19];
    e = '{8'h13, 8'h88, 8'h00, 8'h50, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
          8'hDE, 8'hF0, 8'h50, 8'h12, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    e[16] = CS_EN ? 8'hB9 : 8'h00;
    e[17] = CS_EN ? 8'hB8 : 8'h00;
    issue(32'h1234_5678, 32'h9ABC_DEF0, 9'h012, 1'b1);
    capture(5, 5, -1, 1'b0);
    n_total++; if (stall_n !== 5) $display("FAIL stall_cycles got %0d want 5", stall_n); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (stall_valid[i] !== 1'b1 || stall_data[i] !== 8'h34)
        $display("FAIL stall_hold%0d got v=%b d=%h want v=1 d=34", i, stall_valid[i], stall_data[i]);
      else n_pass++;
    end
    n_total++; if (cap_n !== 20) $display("FAIL stall_len got %0d want 20", cap_n); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_total++;
      if (cap_data[i] !== e[i]) $display("FAIL stall_byte%0d got %h want %h", i, cap_data[i], e[i]);
      else n_pass++;
    end
    n_total++; if (last_hs !== FV + 24) $display("FAIL stall_last_hs got %0d want %0d", last_hs, FV + 24); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(32'h0, 32'h0, 9'h002, 1'b1);
    capture(-1, 0, 5, 1'b1);
    n_total++; if (cap_n !== 20) $display("FAIL b2b_len got %0d want 20", cap_n); else n_pass++;
    n_total++; if (cap_data[7] !== 8'h00) $display("FAIL b2b_seq_byte got %h want 00", cap_data[7]); else n_pass++;
    n_total++; if (ps_count !== 1) $display("FAIL b2b_ps_count got %0d want 1", ps_count); else n_pass++;
    n_total++; if (valid_after !== 0) $display("FAIL b2b_valid_after got %0d want 0", valid_after); else n_pass++;
    n_total++; if (busy_after !== 0) $display("FAIL b2b_busy_after got %0d want 0", busy_after); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int hs;
    bit found;
    int bad;
    logic [7:0] e [0:19];
    e = '{8'h13, 8'h88, 8'h00, 8'h50, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h00,
          8'h80, 8'h00, 8'h51, 8'h11, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    e[16] = CS_EN ? 8'h9B : 8'h00;
    e[17] = CS_EN ? 8'h12 : 8'h00;
    issue(32'h0, 32'h0, 9'h002, 1'b1);
    hs = 0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      readyout = 1'b0;
      if (tx_valid && hs == 8) begin
        reset = 1'b1;
        found = 1'b1;
      end else begin
        @(negedge clk);
        if (tx_valid && tx_ready) hs++;
      end
    end
    n_total++; if (found !== 1'b1) $display("FAIL rst_reach_byte8 got %0d bytes want 8", hs); else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b want 0", tx_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (packetsent !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL rst_quiet got %0d active cycles want 0", bad); else n_pass++;
    issue(32'hFFFF_0000, 32'h8000_8000, 9'h111, 1'b1);
    capture(-1, 0, -1, 1'b0);
    n_total++; if (cap_n !== 20) $display("FAIL rst_new_len got %0d want 20", cap_n); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_total++;
      if (cap_data[i] !== e[i]) $display("FAIL rst_new_byte%0d got %h want %h", i, cap_data[i], e[i]);
      else n_pass++;
    end
    n_total++; if (ps_count !== 1) $display("FAIL rst_new_ps_count got %0d want 1", ps_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_syn_control();
    test_data_segment();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
